fu_logic_pipe: RTL and testbench

Pipelined, parametrised logic/shift functional unit for the execute stage. It accepts one operation per cycle under a valid/ready handshake and carries an issue tag alongside each result. Latency is configurable, and back-pressure and flush are supported. It replaces single-op, single-outstanding logic units, which required re-issue after completion.

---
 rtl/fu_pkg.sv | 27 ++
 rtl/fu_pipe_stage.sv | 46 ++++
 rtl/fu_logic_pipe.sv | 85 ++++++++
 tb/tb_fu_logic_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// Shared definitions for the fu_* execute-stage pipes: opcode encoding and
// the common stall / accept handshake convention.
package fu_pkg;

  localparam int FU_OP_W = 3;

  typedef enum logic [FU_OP_W-1:0] {
    FU_OP_AND  = 3'd0,
    FU_OP_OR   = 3'd1,
    FU_OP_XOR  = 3'd2,
    FU_OP_SLL  = 3'd3,
    FU_OP_SRL  = 3'd4,
    FU_OP_SRA  = 3'd5,
    FU_OP_ANDN = 3'd6,
    FU_OP_PASS = 3'd7
  } fu_op_e;

  // A result waiting on a busy consumer freezes the whole pipe.
  function automatic logic fu_stall(input logic out_valid, input logic out_ready);
    return out_valid & ~out_ready;
  endfunction

  function automatic logic fu_in_ready(input logic stall, input logic flush, input logic rst);
    return ~stall & ~flush & ~rst;
  endfunction

endpackage

// File: rtl/fu_pipe_stage.sv
// One {valid, data, tag} pipeline register. Clear kills the valid bit even
// when the stage is not enabled, so flush wins over a stall.
module fu_pipe_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [TAG_WIDTH-1:0]  o_tag
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [TAG_WIDTH-1:0]  r_tag;

  // Payload only moves with a valid op so bubbles leave the last result in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
    end else begin
      if (i_clear) begin
        r_valid <= 1'b0;
      end else if (i_en) begin
        r_valid <= i_valid;
      end
      if (i_en && i_valid) begin
        r_data <= i_data;
        r_tag  <= i_tag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_tag   = r_tag;

endmodule

// File: rtl/fu_logic_pipe.sv
// Pipelined logic/shift functional unit: the op is evaluated at issue and the
// result travels with its tag through LATENCY register stages.
import fu_pkg::*;

module fu_logic_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FU_OP_W-1:0]    op,
  input  logic [DATA_WIDTH-1:0] data_0,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  tag_out,
  output logic                  idle
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic                  w_stall;
  logic                  w_accept;
  logic [SHW-1:0]        w_shamt;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [LATENCY:0]      w_valid;
  logic [DATA_WIDTH-1:0] w_data [0:LATENCY];
  logic [TAG_WIDTH-1:0]  w_tag  [0:LATENCY];

  assign w_shamt = data_1[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (op)
      FU_OP_AND:  w_alu = data_0 & data_1;
      FU_OP_OR:   w_alu = data_0 | data_1;
      FU_OP_XOR:  w_alu = data_0 ^ data_1;
      FU_OP_SLL:  w_alu = data_0 << w_shamt;
      FU_OP_SRL:  w_alu = data_0 >> w_shamt;
      FU_OP_SRA:  w_alu = $signed(data_0) >>> w_shamt;
      FU_OP_ANDN: w_alu = data_0 & ~data_1;
      FU_OP_PASS: w_alu = data_0;
      default:    w_alu = '0;
    endcase
  end

  assign w_stall  = fu_stall(out_valid, out_ready);
  assign in_ready = fu_in_ready(w_stall, flush, rst);
  assign w_accept = in_valid & in_ready;

  // Slot 0 is the issue side; stage k takes whatever slot k-1 presents.
  assign w_valid[0] = w_accept;
  assign w_data[0]  = w_alu;
  assign w_tag[0]   = tag_in;

  for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
    fu_pipe_stage #(
      .DATA_WIDTH(DATA_WIDTH),
      .TAG_WIDTH (TAG_WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_en   (~w_stall),
      .i_clear(flush),
      .i_valid(w_valid[k-1]),
      .i_data (w_data[k-1]),
      .i_tag  (w_tag[k-1]),
      .o_valid(w_valid[k]),
      .o_data (w_data[k]),
      .o_tag  (w_tag[k])
    );
  end

  assign out_valid = w_valid[LATENCY];
  assign result    = w_data[LATENCY];
  assign tag_out   = w_tag[LATENCY];
  assign idle      = ~(|w_valid[LATENCY:1]) & ~in_valid;

endmodule

// File: tb/tb_fu_logic_pipe.sv
// Directed bench for fu_logic_pipe: one LATENCY=1 and one LATENCY=3 instance
// share the same stimulus; each phase checks the instance it targets.
module tb_fu_logic_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, inValid, outReady;
  logic [2:0]  op;
  logic [31:0] dataA, dataB;
  logic [5:0]  tagIn;

  logic        inReady1, outValid1, idle1;
  logic [31:0] result1;
  logic [5:0]  tagOut1;
  logic        inReady3, outValid3, idle3;
  logic [31:0] result3;
  logic [5:0]  tagOut3;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  fu_logic_pipe #(.DATA_WIDTH(32), .LATENCY(1), .TAG_WIDTH(6)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady1),
    .op(op), .data_0(dataA), .data_1(dataB), .tag_in(tagIn),
    .out_valid(outValid1), .out_ready(outReady), .result(result1),
    .tag_out(tagOut1), .idle(idle1)
  );

  fu_logic_pipe #(.DATA_WIDTH(32), .LATENCY(3), .TAG_WIDTH(6)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady3),
    .op(op), .data_0(dataA), .data_1(dataB), .tag_in(tagIn),
    .out_valid(outValid3), .out_ready(outReady), .result(result3),
    .tag_out(tagOut3), .idle(idle3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of issue-side inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [5:0] t);
    inValid = v;
    op      = o;
    dataA   = a;
    dataB   = b;
    tagIn   = t;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 6'd0);
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    int got;
    int nextTag;
    bit sent4;

    vecs[0] = '{3'd0, 32'h80000001, 32'h00000004, 6'd10, 32'h00000000};
    vecs[1] = '{3'd1, 32'h80000001, 32'h00000004, 6'd11, 32'h80000005};
    vecs[2] = '{3'd2, 32'h80000001, 32'h00000004, 6'd12, 32'h80000005};
    vecs[3] = '{3'd3, 32'h80000001, 32'h00000004, 6'd13, 32'h00000010};
    vecs[4] = '{3'd4, 32'h80000001, 32'h00000004, 6'd14, 32'h08000000};
    vecs[5] = '{3'd5, 32'h80000001, 32'h00000004, 6'd15, 32'hF8000000};
    vecs[6] = '{3'd6, 32'h80000001, 32'h00000004, 6'd16, 32'h80000001};
    vecs[7] = '{3'd7, 32'h80000001, 32'h00000004, 6'd17, 32'h80000001};
    vecs[8] = '{3'd3, 32'h80000001, 32'hFFFFFFE4, 6'd18, 32'h00000010};
    vecs[9] = '{3'd6, 32'hFFFF0000, 32'h0F0F0F0F, 6'd19, 32'hF0F00000};

    flush = 1'b0;
    outReady = 1'b1;
    doReset();
    #1;
    checkOutput("rst outValid1", {31'b0, outValid1}, 32'd0);
    checkOutput("rst idle1", {31'b0, idle1}, 32'd1);
    checkOutput("rst result1", result1, 32'd0);
    checkOutput("rst outValid3", {31'b0, outValid3}, 32'd0);
    checkOutput("rst idle3", {31'b0, idle3}, 32'd1);

    // LATENCY=1 single XOR and one-cycle out_valid pulse
    applyStimulus(1'b1, 3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 6'd5);
    checkOutput("xor inReady", {31'b0, inReady1}, 32'd1);
    checkOutput("xor idle busy", {31'b0, idle1}, 32'd0);
    step();
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 6'd0);
    checkOutput("xor outValid", {31'b0, outValid1}, 32'd1);
    checkOutput("xor result", result1, 32'hFF00FF00);
    checkOutput("xor tag", {26'b0, tagOut1}, 32'd5);
    step();
    checkOutput("xor pulse end", {31'b0, outValid1}, 32'd0);

    // LATENCY=1 opcode table streamed back to back
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      checkOutput($sformatf("vec%0d inReady", i), {31'b0, inReady1}, 32'd1);
      step();
      checkOutput($sformatf("vec%0d outValid", i), {31'b0, outValid1}, 32'd1);
      checkOutput($sformatf("vec%0d result", i), result1, vecs[i].exp);
      checkOutput($sformatf("vec%0d tag", i), {26'b0, tagOut1}, {26'b0, vecs[i].tag});
    end
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 6'd0);
    step();
    checkOutput("table drained", {31'b0, outValid1}, 32'd0);

    // LATENCY=3 streaming: ops accepted on steps 0..3 appear after steps 3..6
    doReset();
    for (int k = 0; k < 9; k++) begin
      if (k < 4) begin
        applyStimulus(1'b1, 3'd7, 32'h01010101 * (k + 1), 32'h0, 6'(k + 1));
        checkOutput($sformatf("stream%0d inReady", k), {31'b0, inReady3}, 32'd1);
      end else begin
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 6'd0);
      end
      checkOutput($sformatf("stream%0d outValid", k), {31'b0, outValid3},
                  (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
      if (k >= 3 && k <= 6) begin
        checkOutput($sformatf("stream%0d tag", k), {26'b0, tagOut3}, k - 2);
        checkOutput($sformatf("stream%0d result", k), result3, 32'h01010101 * (k - 2));
      end
      step();
    end

    // LATENCY=3 back-pressure: freeze for 5 cycles then drain in order
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 3'd7, 32'h01010101 * (k + 1), 32'h0, 6'(k + 1));
      step();
    end
    outReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 3'd7, 32'h04040404, 32'h0, 6'd4);
      checkOutput($sformatf("hold%0d inReady", k), {31'b0, inReady3}, 32'd0);
      checkOutput($sformatf("hold%0d outValid", k), {31'b0, outValid3}, 32'd1);
      checkOutput($sformatf("hold%0d tag", k), {26'b0, tagOut3}, 32'd1);
      checkOutput($sformatf("hold%0d result", k), result3, 32'h01010101);
      step();
    end
    outReady = 1'b1;
    got = 0;
    nextTag = 1;
    sent4 = 1'b0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (!sent4) applyStimulus(1'b1, 3'd7, 32'h04040404, 32'h0, 6'd4);
      else        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 6'd0);
      if (outValid3) begin
        checkOutput("drain tag", {26'b0, tagOut3}, nextTag);
        checkOutput("drain result", result3, 32'h01010101 * nextTag);
        got++;
        nextTag++;
      end
      if (inValid && inReady3) sent4 = 1'b1;
      step();
    end
    checkOutput("drain count", got, 32'd4);
    checkOutput("drain empty", {31'b0, outValid3}, 32'd0);

    // LATENCY=3 flush with two ops in flight and a third presented
    doReset();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 3'd7, 32'hA0 + k, 32'h0, 6'(20 + k));
      step();
    end
    flush = 1'b1;
    applyStimulus(1'b1, 3'd7, 32'hA2, 32'h0, 6'd22);
    checkOutput("flush inReady", {31'b0, inReady3}, 32'd0);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 6'd0);
    checkOutput("flush idle", {31'b0, idle3}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("flush%0d outValid", k), {31'b0, outValid3}, 32'd0);
      step();
    end

    // LATENCY=3 reset while stalled ops are in flight
    outReady = 1'b0;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 3'd7, 32'hB0 + k, 32'h0, 6'(30 + k));
      step();
    end
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 6'd0);
    checkOutput("midrst inReady", {31'b0, inReady3}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("midrst outValid", {31'b0, outValid3}, 32'd0);
    checkOutput("midrst result", result3, 32'd0);
    checkOutput("midrst tag", {26'b0, tagOut3}, 32'd0);
    checkOutput("midrst idle", {31'b0, idle3}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput($sformatf("midrst%0d quiet", k), {31'b0, outValid3}, 32'd0);
    end
    outReady = 1'b1;
    applyStimulus(1'b1, 3'd7, 32'h12345678, 32'h0, 6'd9);
    checkOutput("postrst inReady", {31'b0, inReady3}, 32'd1);
    step();
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 6'd0);
    step();
    step();
    checkOutput("postrst outValid", {31'b0, outValid3}, 32'd1);
    checkOutput("postrst result", result3, 32'h12345678);
    checkOutput("postrst tag", {26'b0, tagOut3}, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
